// File: rtl/vector_plot_pkg.sv
// Shared types for the beam plotter: engine states, FIFO endpoint record and
// the Z-to-colour expansion used at sample capture.
package vector_plot_pkg;

   localparam int COORD_W_DEFAULT = 10;

   typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_e;

   typedef struct packed {
      logic [COORD_W_DEFAULT-1:0] x;
      logic [COORD_W_DEFAULT-1:0] y;
      logic [11:0]                color;
      logic                       on;
   } endpoint_t;

   // RGB arrives as {B,G,R}; the output word is {R4,G4,B4}.
   function automatic logic [11:0] expand_color(input logic [2:0] rgb, input logic [7:0] z);
      return {rgb[0] ? z[7:4] : 4'h0, rgb[1] ? z[7:4] : 4'h0, rgb[2] ? z[7:4] : 4'h0};
   endfunction

endpackage

// File: rtl/vector_beam_plotter_if.sv
// Pixel write-request bus from the plotter to the frame-buffer writer.
interface vector_beam_plotter_if
   import vector_plot_pkg::*;
#(
   parameter int COORD_W = COORD_W_DEFAULT
) ();
   logic [COORD_W-1:0] PIX_X;
   logic [COORD_W-1:0] PIX_Y;
   logic [11:0]        PIX_COLOR;
   logic               PIX_VALID;
   logic               PIX_READY;

   modport master (output PIX_X, PIX_Y, PIX_COLOR, PIX_VALID, input PIX_READY);
   modport slave  (input PIX_X, PIX_Y, PIX_COLOR, PIX_VALID, output PIX_READY);
endinterface

// File: rtl/vec_sample_fifo.sv
// Small synchronous FIFO for sampled beam endpoints; read data is shown
// combinationally from the head entry so a pop can capture it the same cycle.
module vec_sample_fifo
   import vector_plot_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = endpoint_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  T     wdata,
   output T     rdata,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);

   T            mem_q [DEPTH];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic        push_ok, pop_ok;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop_ok  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push on full still lands.
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q + (AW+1)'(push_ok);
      rd_d = rd_q + (AW+1)'(pop_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/vector_beam_plotter.sv
// Samples vector-generator beam endpoints and rasterises each lit segment
// into single-pixel frame-buffer requests using Bresenham stepping.
module vector_beam_plotter
   import vector_plot_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int COORD_W    = COORD_W_DEFAULT
) (
   input  logic                  clk_96MHz,
   input  logic                  RESET,
   input  logic                  BEAM_ENA,
   input  logic [COORD_W-1:0]    X_VECTOR,
   input  logic [COORD_W-1:0]    Y_VECTOR,
   input  logic [7:0]            Z_VECTOR,
   input  logic [2:0]            RGB,
   input  logic                  BEAM_ON,
   vector_beam_plotter_if.master pix,
   output logic                  BUSY,
   output logic                  OVERFLOW
);
   localparam int EW = COORD_W + 2;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [11:0]        color;
      logic               on;
   } ep_t;

   ep_t fifo_wdata, fifo_rdata;
   logic fifo_full, fifo_empty, pop;

   state_e                state_q, state_d;
   ep_t                   ent_q, ent_d;
   logic [COORD_W-1:0]    lx_q, lx_d, ly_q, ly_d, ex_q, ex_d, ey_q, ey_d;
   logic [COORD_W-1:0]    dx_q, dx_d, dy_q, dy_d;
   logic                  sxn_q, sxn_d, syn_q, syn_d, prev_on_q, prev_on_d;
   logic signed [EW-1:0]  err_q, err_d;
   logic [COORD_W-1:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [11:0]           pix_color_q, pix_color_d;
   logic                  pix_valid_q, pix_valid_d, overflow_q, overflow_d;

   assign fifo_wdata = '{x: X_VECTOR, y: Y_VECTOR, color: expand_color(RGB, Z_VECTOR), on: BEAM_ON};

   vec_sample_fifo #(.DEPTH(FIFO_DEPTH), .T(ep_t)) u_fifo (
      .clk   (clk_96MHz),
      .rst   (RESET),
      .push  (BEAM_ENA),
      .pop   (pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Segment setup values, valid while in LOAD.
   logic [COORD_W-1:0]   ld_dx, ld_dy;
   logic                 ld_sxn, ld_syn, ld_at_end;
   logic signed [EW-1:0] ld_err;

   assign ld_sxn    = ent_q.x < lx_q;
   assign ld_syn    = ent_q.y < ly_q;
   assign ld_dx     = ld_sxn ? lx_q - ent_q.x : ent_q.x - lx_q;
   assign ld_dy     = ld_syn ? ly_q - ent_q.y : ent_q.y - ly_q;
   assign ld_err    = $signed({2'b00, ld_dx}) - $signed({2'b00, ld_dy});
   assign ld_at_end = (ent_q.x == lx_q) && (ent_q.y == ly_q);

   // One Bresenham step. LOAD steps from the freshly computed setup so a
   // continuing segment shows its first new pixel on the first DRAW cycle.
   logic                 in_load, step_x, step_y;
   logic [COORD_W-1:0]   st_x, st_y, st_dx, st_dy, nx, ny;
   logic                 st_sxn, st_syn;
   logic signed [EW-1:0] st_err;
   logic signed [EW:0]   e2, pdx, ndy, nerr;

   always_comb begin
      in_load = (state_q == LOAD);
      st_x    = in_load ? lx_q   : pix_x_q;
      st_y    = in_load ? ly_q   : pix_y_q;
      st_dx   = in_load ? ld_dx  : dx_q;
      st_dy   = in_load ? ld_dy  : dy_q;
      st_sxn  = in_load ? ld_sxn : sxn_q;
      st_syn  = in_load ? ld_syn : syn_q;
      st_err  = in_load ? ld_err : err_q;
      e2      = {st_err, 1'b0};
      pdx     = $signed({3'b000, st_dx});
      ndy     = -$signed({3'b000, st_dy});
      step_x  = e2 > ndy;
      step_y  = e2 < pdx;
      nerr    = {st_err[EW-1], st_err} + (step_x ? ndy : '0) + (step_y ? pdx : '0);
      nx      = step_x ? (st_sxn ? st_x - COORD_W'(1) : st_x + COORD_W'(1)) : st_x;
      ny      = step_y ? (st_syn ? st_y - COORD_W'(1) : st_y + COORD_W'(1)) : st_y;
   end

   always_comb begin
      state_d     = state_q;
      ent_d       = ent_q;
      lx_d        = lx_q;
      ly_d        = ly_q;
      ex_d        = ex_q;
      ey_d        = ey_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      sxn_d       = sxn_q;
      syn_d       = syn_q;
      err_d       = err_q;
      prev_on_d   = prev_on_q;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      pix_color_d = pix_color_q;
      pix_valid_d = pix_valid_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               ent_d   = fifo_rdata;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (!ent_q.on) begin
               lx_d      = ent_q.x;
               ly_d      = ent_q.y;
               prev_on_d = 1'b0;
               state_d   = IDLE;
            end else begin
               dx_d        = ld_dx;
               dy_d        = ld_dy;
               sxn_d       = ld_sxn;
               syn_d       = ld_syn;
               err_d       = ld_err;
               ex_d        = ent_q.x;
               ey_d        = ent_q.y;
               pix_color_d = ent_q.color;
               if (!prev_on_q) begin
                  pix_x_d     = lx_q;
                  pix_y_d     = ly_q;
                  pix_valid_d = 1'b1;
                  state_d     = DRAW;
               end else if (ld_at_end) begin
                  state_d = IDLE;
               end else begin
                  pix_x_d     = nx;
                  pix_y_d     = ny;
                  err_d       = nerr[EW-1:0];
                  pix_valid_d = 1'b1;
                  state_d     = DRAW;
               end
            end
         end
         DRAW: begin
            if (pix.PIX_READY) begin
               if (pix_x_q == ex_q && pix_y_q == ey_q) begin
                  pix_valid_d = 1'b0;
                  lx_d        = ex_q;
                  ly_d        = ey_q;
                  prev_on_d   = 1'b1;
                  state_d     = IDLE;
               end else begin
                  pix_x_d = nx;
                  pix_y_d = ny;
                  err_d   = nerr[EW-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A full FIFO can only be drained by an IDLE pop; otherwise the sample is lost.
   assign overflow_d = overflow_q || (BEAM_ENA && fifo_full && !pop);

   always_ff @(posedge clk_96MHz or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         ent_q       <= '0;
         lx_q        <= '0;
         ly_q        <= '0;
         ex_q        <= '0;
         ey_q        <= '0;
         dx_q        <= '0;
         dy_q        <= '0;
         sxn_q       <= 1'b0;
         syn_q       <= 1'b0;
         err_q       <= '0;
         prev_on_q   <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_color_q <= '0;
         pix_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ent_q       <= ent_d;
         lx_q        <= lx_d;
         ly_q        <= ly_d;
         ex_q        <= ex_d;
         ey_q        <= ey_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         sxn_q       <= sxn_d;
         syn_q       <= syn_d;
         err_q       <= err_d;
         prev_on_q   <= prev_on_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         pix_color_q <= pix_color_d;
         pix_valid_q <= pix_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign pix.PIX_X     = pix_x_q;
   assign pix.PIX_Y     = pix_y_q;
   assign pix.PIX_COLOR = pix_color_q;
   assign pix.PIX_VALID = pix_valid_q;
   assign BUSY          = !fifo_empty || (state_q != IDLE);
   assign OVERFLOW      = overflow_q;

endmodule

// File: tb/tb_vector_beam_plotter.sv
// Self-checking bench: scoreboard of expected pixels fed by a reference line
// model, a table of samples with expected pixel counts, and timing sequences.
module tb_vector_beam_plotter;
   import vector_plot_pkg::*;

   localparam int CW = 10;

   logic          clk_96MHz = 1'b0;
   logic          RESET = 1'b1;
   logic          BEAM_ENA = 1'b0;
   logic          BEAM_ON = 1'b0;
   logic [CW-1:0] X_VECTOR = '0;
   logic [CW-1:0] Y_VECTOR = '0;
   logic [7:0]    Z_VECTOR = '0;
   logic [2:0]    RGB = '0;
   logic          BUSY, OVERFLOW;

   vector_beam_plotter_if #(.COORD_W(CW)) pix ();

   vector_beam_plotter #(.FIFO_DEPTH(4), .COORD_W(CW)) dut (
      .clk_96MHz (clk_96MHz),
      .RESET     (RESET),
      .BEAM_ENA  (BEAM_ENA),
      .X_VECTOR  (X_VECTOR),
      .Y_VECTOR  (Y_VECTOR),
      .Z_VECTOR  (Z_VECTOR),
      .RGB       (RGB),
      .BEAM_ON   (BEAM_ON),
      .pix       (pix),
      .BUSY      (BUSY),
      .OVERFLOW  (OVERFLOW)
   );

   always #5 clk_96MHz = ~clk_96MHz;

   typedef struct {int x; int y; int c;} pix_t;
   pix_t exp_q[$];
   int   n_checks = 0, n_pass = 0, pix_cnt = 0;
   int   m_lx = 0, m_ly = 0;
   bit   m_on = 0;

   function automatic void chk(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endfunction

   // Scoreboard: a handshake seen at the negedge completes at the next posedge.
   always @(negedge clk_96MHz) begin
      if (!RESET && pix.PIX_VALID && pix.PIX_READY) begin
         pix_t e;
         pix_cnt++;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_pixel: got (%0d,%0d,%03h) expected none",
                     pix.PIX_X, pix.PIX_Y, pix.PIX_COLOR);
         end else begin
            e = exp_q.pop_front();
            if (int'(pix.PIX_X) == e.x && int'(pix.PIX_Y) == e.y && int'(pix.PIX_COLOR) == e.c)
               n_pass++;
            else
               $display("FAIL pixel: got (%0d,%0d,%03h) expected (%0d,%0d,%03h)",
                        pix.PIX_X, pix.PIX_Y, pix.PIX_COLOR, e.x, e.y, e.c);
         end
      end
   end

   function automatic int ref_color(input logic [2:0] rgb, input logic [7:0] z);
      int n = int'(z) / 16;
      return (rgb[0] ? n * 256 : 0) + (rgb[1] ? n * 16 : 0) + (rgb[2] ? n : 0);
   endfunction

   function automatic void push_pix(input int x, input int y, input int c);
      pix_t p;
      p.x = x; p.y = y; p.c = c;
      exp_q.push_back(p);
   endfunction

   // Reference rasteriser over plain integers.
   function automatic void model(input int x, input int y, input logic [2:0] rgb,
                                 input logic [7:0] z, input bit on);
      int cx, cy, dx, dy, sx, sy, err, e2, c;
      if (on) begin
         c  = ref_color(rgb, z);
         cx = m_lx; cy = m_ly;
         dx = (x > cx) ? x - cx : cx - x;
         dy = (y > cy) ? y - cy : cy - y;
         sx = (x >= cx) ? 1 : -1;
         sy = (y >= cy) ? 1 : -1;
         err = dx - dy;
         if (!m_on) push_pix(cx, cy, c);
         while (cx != x || cy != y) begin
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; cx += sx; end
            if (e2 < dx)  begin err += dx; cy += sy; end
            push_pix(cx, cy, c);
         end
      end
      m_lx = x; m_ly = y; m_on = on;
   endfunction

   task automatic drive(input int x, input int y, input logic [2:0] rgb,
                        input logic [7:0] z, input bit on, input bit mdl);
      @(posedge clk_96MHz); #1;
      BEAM_ENA = 1'b1;
      X_VECTOR = CW'(x); Y_VECTOR = CW'(y);
      RGB = rgb; Z_VECTOR = z; BEAM_ON = on;
      if (mdl) model(x, y, rgb, z, on);
   endtask

   task automatic ena_off();
      @(posedge clk_96MHz); #1;
      BEAM_ENA = 1'b0;
   endtask

   task automatic send(input int x, input int y, input logic [2:0] rgb,
                       input logic [7:0] z, input bit on);
      drive(x, y, rgb, z, on, 1'b1);
      ena_off();
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      do begin
         @(negedge clk_96MHz);
         k++;
      end while ((BUSY || pix.PIX_VALID) && k < 3000);
      chk(k < 3000, {name, "_drain"}, k, 3000);
   endtask

   task automatic wait_pix(input int n, input string name);
      int k = 0;
      while (pix_cnt < n && k < 1000) begin
         @(negedge clk_96MHz);
         k++;
      end
      chk(k < 1000, {name, "_wait"}, pix_cnt, n);
   endtask

   typedef struct {
      int x; int y; logic [2:0] rgb; logic [7:0] z; bit on; int exp_n;
   } vec_t;

   initial begin
      vec_t tbl[8];
      int   c0, n, k;
      logic [3:0] lat;
      logic [CW-1:0] hx, hy;
      logic [11:0] hc;
      int   sx[6], sy[6];

      tbl[0] = '{30, 30, 3'b000, 8'h00, 1'b0, 0};
      tbl[1] = '{35, 32, 3'b100, 8'hFF, 1'b1, 6};
      tbl[2] = '{35, 32, 3'b100, 8'hFF, 1'b1, 0};
      tbl[3] = '{30, 40, 3'b011, 8'hA5, 1'b1, 8};
      tbl[4] = '{ 7,  7, 3'b000, 8'h00, 1'b0, 0};
      tbl[5] = '{ 7,  7, 3'b101, 8'h77, 1'b1, 1};
      tbl[6] = '{ 0,  0, 3'b111, 8'h1F, 1'b1, 7};
      tbl[7] = '{ 3,  0, 3'b111, 8'h1F, 1'b1, 3};
      sx = '{0, 0, 1, 1, 2, 2};
      sy = '{0, 1, 2, 3, 4, 5};

      pix.PIX_READY = 1'b1;
      repeat (2) @(negedge clk_96MHz);
      chk(pix.PIX_VALID == 1'b0, "rst_valid", int'(pix.PIX_VALID), 0);
      chk(pix.PIX_X == '0, "rst_x", int'(pix.PIX_X), 0);
      chk(pix.PIX_Y == '0, "rst_y", int'(pix.PIX_Y), 0);
      chk(pix.PIX_COLOR == '0, "rst_color", int'(pix.PIX_COLOR), 0);
      chk(BUSY == 1'b0, "rst_busy", int'(BUSY), 0);
      chk(OVERFLOW == 1'b0, "rst_overflow", int'(OVERFLOW), 0);
      @(posedge clk_96MHz); #1 RESET = 1'b0;

      // Dot with latency: valid appears three cycles after the strobe cycle.
      send(100, 50, 3'b000, 8'h00, 1'b0);
      wait_idle("move1");
      c0 = pix_cnt;
      drive(100, 50, 3'b111, 8'hF0, 1'b1, 1'b1);
      @(negedge clk_96MHz); lat[0] = pix.PIX_VALID;
      @(posedge clk_96MHz); #1 BEAM_ENA = 1'b0;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk_96MHz); lat[i] = pix.PIX_VALID;
      end
      chk(lat == 4'b1000, "dot_latency", int'(lat), 8);
      wait_idle("dot");
      chk(pix_cnt - c0 == 1, "dot_count", pix_cnt - c0, 1);

      // Horizontal line streams one pixel per cycle.
      send(10, 20, 3'b000, 8'h00, 1'b0);
      wait_idle("move2");
      send(14, 20, 3'b001, 8'h80, 1'b1);
      k = 0;
      while (!pix.PIX_VALID && k < 20) begin @(negedge clk_96MHz); k++; end
      n = 0;
      while (pix.PIX_VALID && n < 20) begin n++; @(negedge clk_96MHz); end
      chk(n == 5, "hline_run", n, 5);
      wait_idle("hline");

      // Chained steep line with hand-derived coordinates.
      send(0, 0, 3'b000, 8'h00, 1'b0);
      wait_idle("move3");
      for (int i = 0; i < 6; i++) push_pix(sx[i], sy[i], 12'h030);
      push_pix(2, 6, 12'h030);
      m_lx = 2; m_ly = 6; m_on = 1'b1;
      drive(2, 5, 3'b010, 8'h3C, 1'b1, 1'b0);
      ena_off();
      drive(2, 6, 3'b010, 8'h3C, 1'b1, 1'b0);
      ena_off();
      wait_idle("steep");

      for (int i = 0; i < 8; i++) begin
         c0 = pix_cnt;
         send(tbl[i].x, tbl[i].y, tbl[i].rgb, tbl[i].z, tbl[i].on);
         wait_idle($sformatf("tbl%0d", i));
         chk(pix_cnt - c0 == tbl[i].exp_n, $sformatf("tbl%0d_count", i), pix_cnt - c0, tbl[i].exp_n);
      end

      // Backpressure mid-line: outputs must hold.
      send(0, 0, 3'b000, 8'h00, 1'b0);
      wait_idle("move4");
      c0 = pix_cnt;
      send(9, 0, 3'b111, 8'hFF, 1'b1);
      wait_pix(c0 + 3, "bp");
      @(posedge clk_96MHz); #1 pix.PIX_READY = 1'b0;
      hx = pix.PIX_X; hy = pix.PIX_Y; hc = pix.PIX_COLOR;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_96MHz);
         chk(pix.PIX_VALID && pix.PIX_X == hx && pix.PIX_Y == hy && pix.PIX_COLOR == hc,
             $sformatf("bp_hold%0d", i), int'(pix.PIX_X), int'(hx));
      end
      @(posedge clk_96MHz); #1 pix.PIX_READY = 1'b1;
      wait_idle("bp");
      chk(pix_cnt - c0 == 10, "bp_count", pix_cnt - c0, 10);

      // Overflow: six back-to-back samples while the engine is stalled.
      send(0, 0, 3'b000, 8'h00, 1'b0);
      wait_idle("move5");
      chk(OVERFLOW == 1'b0, "ovf_pre", int'(OVERFLOW), 0);
      @(posedge clk_96MHz); #1 pix.PIX_READY = 1'b0;
      drive(3, 0, 3'b001, 8'hC0, 1'b1, 1'b1);
      drive(3, 3, 3'b001, 8'hC0, 1'b1, 1'b1);
      drive(0, 3, 3'b001, 8'hC0, 1'b1, 1'b1);
      drive(0, 0, 3'b001, 8'hC0, 1'b1, 1'b1);
      drive(5, 5, 3'b001, 8'hC0, 1'b1, 1'b1);
      drive(9, 9, 3'b001, 8'hC0, 1'b1, 1'b0);
      ena_off();
      @(negedge clk_96MHz);
      chk(OVERFLOW == 1'b1, "ovf_set", int'(OVERFLOW), 1);
      chk(BUSY == 1'b1, "ovf_busy", int'(BUSY), 1);
      c0 = pix_cnt;
      @(posedge clk_96MHz); #1 pix.PIX_READY = 1'b1;
      wait_idle("ovf");
      chk(pix_cnt - c0 == 18, "ovf_count", pix_cnt - c0, 18);
      chk(OVERFLOW == 1'b1, "ovf_sticky", int'(OVERFLOW), 1);

      // Reset during a 100-pixel line.
      send(0, 0, 3'b000, 8'h00, 1'b0);
      wait_idle("move6");
      c0 = pix_cnt;
      send(99, 0, 3'b111, 8'hFF, 1'b1);
      wait_pix(c0 + 10, "rst_mid");
      @(posedge clk_96MHz); #1 RESET = 1'b1;
      exp_q.delete();
      @(negedge clk_96MHz);
      chk(pix.PIX_VALID == 1'b0, "rst_mid_valid", int'(pix.PIX_VALID), 0);
      chk(BUSY == 1'b0, "rst_mid_busy", int'(BUSY), 0);
      chk(OVERFLOW == 1'b0, "rst_mid_overflow", int'(OVERFLOW), 0);
      @(posedge clk_96MHz); #1 RESET = 1'b0;
      m_lx = 0; m_ly = 0; m_on = 1'b0;
      c0 = pix_cnt;
      send(0, 0, 3'b000, 8'h00, 1'b0);
      send(0, 0, 3'b100, 8'h50, 1'b1);
      wait_idle("post_rst");
      chk(pix_cnt - c0 == 1, "post_rst_count", pix_cnt - c0, 1);

      chk(exp_q.size() == 0, "scoreboard_left", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vector_beam_plotter.md
# vector_beam_plotter

Downstream consumer of the vector generator's beam outputs. Samples beam position, intensity and colour on each beam enable, buffers endpoints in a small FIFO, and rasterises each beam-on segment between successive samples into single-pixel write requests for the frame-buffer writer. Sits between vg_top's DVX/DVY/linscale outputs and the raster frame-buffer port, in the clk_96MHz domain.

## Interface
Parameters:
- FIFO_DEPTH, 4: endpoint FIFO entries (power of two, ≥2)
- COORD_W, 10: pixel coordinate width

Ports:
- clk_96MHz  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- BEAM_ENA  in  1  one-cycle sample strobe
- X_VECTOR  in  COORD_W  beam X, unsigned
- Y_VECTOR  in  COORD_W  beam Y, unsigned
- Z_VECTOR  in  8  intensity (linscale)
- RGB  in  3  colour bits {B,G,R}
- BEAM_ON  in  1  beam lit for the segment ending at this sample
- PIX_X  out  COORD_W  pixel X
- PIX_Y  out  COORD_W  pixel Y
- PIX_COLOR  out  12  {R4,G4,B4}
- PIX_VALID  out  1  pixel request valid
- PIX_READY  in  1  frame-buffer accepts
- BUSY  out  1  FIFO non-empty or engine not IDLE
- OVERFLOW  out  1  sticky: a sample was dropped

## Operation
- Sample capture: on a cycle with BEAM_ENA=1, push {X,Y,color,BEAM_ON} into the FIFO. color per channel = RGB bit ? Z_VECTOR[7:4] : 4'h0.
- FIFO full while BEAM_ENA=1: the sample is dropped and OVERFLOW sets. OVERFLOW clears only on RESET.
- Engine registers: last position (lx,ly), prev_on, both reset to 0.
- States:
  - IDLE: if FIFO non-empty, pop and go to LOAD.
  - LOAD:
    - BEAM_ON=0: update lx,ly; set prev_on=0; go to IDLE.
    - BEAM_ON=1: compute dx=|x-lx|, dy=|y-ly|, sx, sy, err=dx-dy (COORD_W+2 signed). Current point = (lx,ly). Go to DRAW.
  - DRAW: standard Bresenham, one step per accepted pixel.
    - Start pixel is emitted only if prev_on=0.
    - Each subsequent point is emitted, up to and including the endpoint.
    - After the endpoint is accepted, or immediately if no pixel remains, set lx,ly to the endpoint, set prev_on=1, and go to IDLE.
- Zero-length segment: prev_on=0 gives exactly one pixel (a dot); prev_on=1 gives no pixel.
- PIX_* hold stable while PIX_VALID=1 and PIX_READY=0. A transfer occurs when both are 1.
- All arithmetic is unsigned coordinates with signed COORD_W+2 error. Coordinates never wrap because steps stop at the endpoint.

## Timing
- Reset values: PIX_VALID=0, PIX_X=0, PIX_Y=0, PIX_COLOR=0, BUSY=0, OVERFLOW=0, FIFO empty, state IDLE.
- Latency: BEAM_ENA at cycle n puts the entry in the FIFO at n+1. IDLE pops at n+1, LOAD runs at n+2, the first PIX_VALID appears at n+3 (engine idle, FIFO previously empty).
- Throughput: one pixel per cycle while PIX_READY=1. A segment of N emitted pixels occupies N cycles in DRAW, plus one IDLE and one LOAD cycle.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push is accepted.
- RESET mid-segment: immediate abort, everything returns to reset values, and no partial state is retained.

## Structure
- Package vector_plot_pkg holds:
  - COORD_W default
  - state enum {IDLE, LOAD, DRAW}
  - endpoint struct {x, y, color[11:0], on}
  - color-expansion function
- Sub-module vec_sample_fifo: synchronous FIFO with push, pop, full, empty and the endpoint struct payload. The engine FSM and the Bresenham datapath stay in the top module.

## Test plan
- Dot: move to (100,50), then BEAM_ON=1 sample at (100,50), RGB=3'b111, Z=8'hF0 -> exactly one pixel (100,50), color 12'hFFF.
- Horizontal line: move (10,20), then on-sample (14,20) RGB=001 Z=8'h80 -> pixels x=10..14, y=20, color 12'h800, in order, one per cycle with PIX_READY=1.
- Chained steep line: on-samples (0,0)→(2,5) after a move to (0,0) -> (0,0),(0,1),(1,2),(1,3),(2,4),(2,5). The next on-sample (2,6) emits only (2,6).
- Backpressure: hold PIX_READY=0 for 5 cycles mid-line -> PIX_* stable and no pixel lost or duplicated.
- Overflow: push 6 samples on consecutive BEAM_ENA cycles with PIX_READY=0 and FIFO_DEPTH=4 -> OVERFLOW=1, and the later samples are dropped.
- Reset during DRAW of a 100-pixel line -> PIX_VALID=0 next cycle, BUSY=0. A following move to (0,0) plus dot produces (0,0) only.
